// File: rtl/dbus_responder_if.sv
// Data-bus handshake between the memory stage (master) and the data responder (slave).
// Request fields are held by the master until data_ok; response fields are valid only with data_ok.
interface dbus_responder_if;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;

    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        dresp_err;

    modport master (
        output dreq_valid,
        output dreq_addr,
        output dreq_size,
        output dreq_strobe,
        output dreq_data,
        input  dresp_addr_ok,
        input  dresp_data_ok,
        input  dresp_data,
        input  dresp_err
    );

    modport slave (
        input  dreq_valid,
        input  dreq_addr,
        input  dreq_size,
        input  dreq_strobe,
        input  dreq_data,
        output dresp_addr_ok,
        output dresp_data_ok,
        output dresp_data,
        output dresp_err
    );
endinterface

// File: rtl/dbus_responder.sv
// Single-outstanding data-memory responder: fixed-latency addr_ok/data_ok handshake over a
// byte-strobed 64-bit word array. Requests are fully decoded at accept time.
module dbus_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input  logic             clk,
    input  logic             resetn,
    dbus_responder_if.slave  bus
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // ------------------------------------------------------------------
    // Request decode (only meaningful in IDLE, where the request is latched)
    // ------------------------------------------------------------------
    logic [60:0]      word_off;
    logic             in_range;
    logic [3:0]       nbytes;
    logic             aligned;
    logic [7:0]       lane_mask;
    logic             strobe_ok;
    logic             req_err;
    logic [IDX_W-1:0] req_idx;

    assign word_off = bus.dreq_addr[63:3] - BASE_ADDR[63:3];
    assign in_range = (bus.dreq_addr >= BASE_ADDR) && (word_off < 61'(DEPTH_WORDS));
    assign req_idx  = word_off[IDX_W-1:0];

    always_comb begin
        nbytes  = 4'd0;
        aligned = 1'b0;
        case (bus.dreq_size)
            3'd0: begin nbytes = 4'd1; aligned = 1'b1;                        end
            3'd1: begin nbytes = 4'd2; aligned = (bus.dreq_addr[0]   == 1'b0);  end
            3'd2: begin nbytes = 4'd4; aligned = (bus.dreq_addr[1:0] == 2'b00); end
            3'd3: begin nbytes = 4'd8; aligned = (bus.dreq_addr[2:0] == 3'b000); end
            default: begin nbytes = 4'd0; aligned = 1'b0; end
        endcase
    end

    // A byte lane may be strobed only if it lies inside [addr[2:0], addr[2:0]+nbytes).
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_mask[gi] = (4'(gi) >= {1'b0, bus.dreq_addr[2:0]}) &&
                                   (4'(gi) <  ({1'b0, bus.dreq_addr[2:0]} + nbytes));
        end
    endgenerate

    assign strobe_ok = ((bus.dreq_strobe & ~lane_mask) == 8'h00);
    assign req_err   = !in_range || bus.dreq_size[2] || !aligned || !strobe_ok;

    // ------------------------------------------------------------------
    // Control FSM and latched request
    // ------------------------------------------------------------------
    logic [1:0]       state_q,  state_d;
    logic [3:0]       cnt_q,    cnt_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [7:0]       strobe_q, strobe_d;
    logic [63:0]      wdata_q,  wdata_d;
    logic             err_q,    err_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.dreq_valid) begin
                    idx_d    = req_idx;
                    strobe_d = bus.dreq_strobe;
                    wdata_d  = bus.dreq_data;
                    err_d    = req_err;
                    cnt_d    = CNT_INIT;
                    state_d  = (LATENCY > 1) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            strobe_q <= 8'h00;
            wdata_q  <= 64'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Word array: registered read, byte-enabled write on the RESP edge
    // ------------------------------------------------------------------
    logic [63:0]      mem [DEPTH_WORDS];
    logic [63:0]      rdata_q;
    logic [IDX_W-1:0] rd_idx;
    logic             resp;
    logic             mem_we;

    // With LATENCY=1 the read must be issued on the accept edge itself, before idx_q is loaded.
    assign rd_idx = (state_q == ST_IDLE) ? req_idx : idx_q;
    assign resp   = (state_q == ST_RESP);
    assign mem_we = resp && !err_q && (strobe_q != 8'h00);

    always_ff @(posedge clk) begin
        rdata_q <= mem[rd_idx];
        if (mem_we) begin
            for (int k = 0; k < 8; k++) begin
                if (strobe_q[k]) begin
                    mem[idx_q][k*8 +: 8] <= wdata_q[k*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response outputs; addr_ok is held low while reset is asserted
    // ------------------------------------------------------------------
    assign bus.dresp_addr_ok = resetn && (state_q == ST_IDLE) && bus.dreq_valid;
    assign bus.dresp_data_ok = resp;
    assign bus.dresp_err     = resp && err_q;
    assign bus.dresp_data    = (resp && !err_q && (strobe_q == 8'h00)) ? rdata_q : 64'h0;

endmodule
